// File: rtl/seg7_scan_readback_pkg.sv
// rtl/seg7_scan_readback_pkg.sv - seven-segment pattern table and decoded-digit type
package seg7_scan_readback_pkg;

    // Active-low segment patterns, bit0=a .. bit6=g; must track the encoder's table exactly.
    localparam logic [6:0] SEG7_0     = 7'h40;
    localparam logic [6:0] SEG7_1     = 7'h79;
    localparam logic [6:0] SEG7_2     = 7'h24;
    localparam logic [6:0] SEG7_3     = 7'h30;
    localparam logic [6:0] SEG7_4     = 7'h19;
    localparam logic [6:0] SEG7_5     = 7'h12;
    localparam logic [6:0] SEG7_6     = 7'h02;
    localparam logic [6:0] SEG7_7     = 7'h78;
    localparam logic [6:0] SEG7_8     = 7'h00;
    localparam logic [6:0] SEG7_9     = 7'h18;
    localparam logic [6:0] SEG7_A     = 7'h08;
    localparam logic [6:0] SEG7_B     = 7'h03;
    localparam logic [6:0] SEG7_C     = 7'h46;
    localparam logic [6:0] SEG7_D     = 7'h21;
    localparam logic [6:0] SEG7_E     = 7'h06;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       err;
    } seg7_digit_t;

endpackage

// File: rtl/seg7_scan_readback_if.sv
// rtl/seg7_scan_readback_if.sv - scanned display bus and frame delivery handshake
interface seg7_scan_readback_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              Seg_in;
    logic [NUM_DIGITS-1:0]   Dig_en_n;
    logic                    Ack_in;
    logic [4*NUM_DIGITS-1:0] Digits_out;
    logic [NUM_DIGITS-1:0]   Blank_out;
    logic [NUM_DIGITS-1:0]   Err_out;
    logic                    Valid_out;

    modport master (
        output Seg_in, Dig_en_n, Ack_in,
        input  Digits_out, Blank_out, Err_out, Valid_out
    );

    modport slave (
        input  Seg_in, Dig_en_n, Ack_in,
        output Digits_out, Blank_out, Err_out, Valid_out
    );
endinterface

// File: rtl/seg7_scan_readback_decode.sv
// rtl/seg7_scan_readback_decode.sv - combinational 7-seg pattern to nibble/blank/err
module seg7_pattern_decode
    import seg7_scan_readback_pkg::*;
(
    input  logic [6:0]  pattern,
    output seg7_digit_t digit
);

    always_comb begin
        digit = '{nibble: 4'h0, blank: 1'b0, err: 1'b0};
        case (pattern)
            SEG7_0:     digit.nibble = 4'h0;
            SEG7_1:     digit.nibble = 4'h1;
            SEG7_2:     digit.nibble = 4'h2;
            SEG7_3:     digit.nibble = 4'h3;
            SEG7_4:     digit.nibble = 4'h4;
            SEG7_5:     digit.nibble = 4'h5;
            SEG7_6:     digit.nibble = 4'h6;
            SEG7_7:     digit.nibble = 4'h7;
            SEG7_8:     digit.nibble = 4'h8;
            SEG7_9:     digit.nibble = 4'h9;
            SEG7_A:     digit.nibble = 4'hA;
            SEG7_B:     digit.nibble = 4'hB;
            SEG7_C:     digit.nibble = 4'hC;
            SEG7_D:     digit.nibble = 4'hD;
            SEG7_E:     digit.nibble = 4'hE;
            SEG7_BLANK: begin
                digit.nibble = 4'hF;
                digit.blank  = 1'b1;
            end
            default:    digit.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_readback.sv
// rtl/seg7_scan_readback.sv - rebuilds stable digit frames from a scanned active-low 7-seg bus
module seg7_scan_readback
    import seg7_scan_readback_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_SCANS = 3,
    parameter int SETTLE       = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    seg7_scan_readback_if.slave bus
);

    localparam int CW = $clog2(SETTLE + 2);
    localparam int MW = $clog2(STABLE_SCANS + 1);
    localparam logic [CW-1:0]         SETTLE_CNT = CW'(SETTLE);
    localparam logic [CW-1:0]         SETTLE_SAT = CW'(SETTLE + 1);
    localparam logic [MW-1:0]         MATCH_FULL = MW'(STABLE_SCANS);
    localparam logic [NUM_DIGITS-1:0] ALL_DIGITS = '1;
    localparam logic [NUM_DIGITS-1:0] ONE_DIGIT  = NUM_DIGITS'(1);

    logic [6:0]                   seg_r;
    logic [NUM_DIGITS-1:0]        en_r, en_q, act;
    logic [CW-1:0]                settle_cnt, cnt_now;
    logic [MW-1:0]                match_cnt, match_next;
    logic [NUM_DIGITS-1:0]        mask, mask_next;
    logic                         single_hot, multi_hot, capture, complete, qualify;
    logic                         delivered, pending, valid_q;
    seg7_digit_t                  dec;
    seg7_digit_t [NUM_DIGITS-1:0] slot, frame, prev_frame, out_frame;
    logic [4*NUM_DIGITS-1:0]      out_dig;
    logic [NUM_DIGITS-1:0]        out_blank, out_err;

    seg7_pattern_decode u_decode (
        .pattern (seg_r),
        .digit   (dec)
    );

    always_comb begin
        act        = ~en_r;
        single_hot = (act != '0) && ((act & (act - ONE_DIGIT)) == '0);
        multi_hot  = (act != '0) && !single_hot;

        // Count 1 on the first cycle of a new enable pattern, saturating one past SETTLE
        // so the capture fires exactly once per activation.
        if (en_r != en_q)
            cnt_now = CW'(1);
        else if (settle_cnt == SETTLE_SAT)
            cnt_now = settle_cnt;
        else
            cnt_now = settle_cnt + CW'(1);

        capture   = single_hot && (cnt_now == SETTLE_CNT);
        frame     = slot;
        mask_next = mask;
        if (capture) begin
            for (int k = 0; k < NUM_DIGITS; k++)
                if (act[k]) frame[k] = dec;
            mask_next = mask | act;
        end
        complete = capture && (mask_next == ALL_DIGITS);

        if (frame == prev_frame)
            match_next = (match_cnt == MATCH_FULL) ? match_cnt : match_cnt + MW'(1);
        else
            match_next = MW'(1);

        qualify = complete && (match_next == MATCH_FULL) &&
                  (!delivered || (frame != out_frame));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            seg_r      <= '0;
            en_r       <= '0;
            en_q       <= '0;
            settle_cnt <= '0;
            slot       <= '0;
            mask       <= '0;
            prev_frame <= '0;
            match_cnt  <= '0;
            out_frame  <= '0;
            delivered  <= 1'b0;
            pending    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            seg_r      <= bus.Seg_in;
            en_r       <= bus.Dig_en_n;
            en_q       <= en_r;
            settle_cnt <= cnt_now;
            slot       <= frame;

            if (multi_hot || complete)
                mask <= '0;
            else
                mask <= mask_next;

            if (complete) begin
                prev_frame <= frame;
                match_cnt  <= match_next;
            end

            // A completion landing on the ack edge is parked in pending; prev_frame still
            // holds that frame on the following cycle, so it is delivered from there.
            if (valid_q) begin
                if (bus.Ack_in) begin
                    valid_q <= 1'b0;
                    pending <= qualify;
                end
            end else if (pending) begin
                out_frame <= prev_frame;
                valid_q   <= 1'b1;
                pending   <= 1'b0;
                delivered <= 1'b1;
            end else if (qualify) begin
                out_frame <= frame;
                valid_q   <= 1'b1;
                delivered <= 1'b1;
            end
        end
    end

    always_comb begin
        out_dig   = '0;
        out_blank = '0;
        out_err   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            out_dig[4*k +: 4] = out_frame[k].nibble;
            out_blank[k]      = out_frame[k].blank;
            out_err[k]        = out_frame[k].err;
        end
    end

    assign bus.Digits_out = out_dig;
    assign bus.Blank_out  = out_blank;
    assign bus.Err_out    = out_err;
    assign bus.Valid_out  = valid_q;

endmodule

// File: tb/tb_seg7_scan_readback.sv
// tb/tb_seg7_scan_readback.sv - directed bench for seg7_scan_readback
module tb_seg7_scan_readback;

    localparam int ND = 4;

    // Frames packed digit3..digit0, 7 bits each
    localparam logic [27:0] F1234 = {7'h19, 7'h30, 7'h24, 7'h79};
    localparam logic [27:0] F1235 = {7'h12, 7'h30, 7'h24, 7'h79};
    localparam logic [27:0] FBLER = {7'h55, 7'h7F, 7'h24, 7'h79};

    logic Clk = 1'b0;
    logic Rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 Clk = ~Clk;

    seg7_scan_readback_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_readback #(
        .NUM_DIGITS   (ND),
        .STABLE_SCANS (3),
        .SETTLE       (2)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic valid, input logic [15:0] dig,
                             input logic [3:0] blank, input logic [3:0] err);
        check_eq({tag, "_valid"}, bus.Valid_out, valid);
        check_eq({tag, "_digits"}, bus.Digits_out, dig);
        check_eq({tag, "_blank"}, bus.Blank_out, blank);
        check_eq({tag, "_err"}, bus.Err_out, err);
    endtask

    task automatic show(input int k, input logic [6:0] pat, input int cycles);
        bus.Dig_en_n = ~(ND'(1) << k);
        bus.Seg_in   = pat;
        repeat (cycles) @(negedge Clk);
    endtask

    task automatic scan_frame(input logic [27:0] pats);
        for (int k = 0; k < ND; k++)
            show(k, pats[7*k +: 7], 3);
    endtask

    task automatic do_ack();
        bus.Ack_in = 1'b1;
        @(negedge Clk);
        bus.Ack_in = 1'b0;
        check_eq("ack_drop", bus.Valid_out, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        Rst_n        = 1'b0;
        bus.Seg_in   = 7'h7F;
        bus.Dig_en_n = '1;
        bus.Ack_in   = 1'b0;
        repeat (3) @(negedge Clk);
        check_out("reset", 1'b0, 16'h0000, 4'h0, 4'h0);
        Rst_n = 1'b1;

        // Stable 1234 with exact delivery latency
        scan_frame(F1234);
        scan_frame(F1234);
        check_eq("t2_not_yet", bus.Valid_out, 1'b0);
        for (int k = 0; k < ND - 1; k++) show(k, F1234[7*k +: 7], 3);
        show(3, 7'h19, 2);
        check_eq("t2_before_capture", bus.Valid_out, 1'b0);
        @(negedge Clk);
        check_out("t2_deliver", 1'b1, 16'h4321, 4'h0, 4'h0);
        scan_frame(F1234);
        check_out("t2_hold", 1'b1, 16'h4321, 4'h0, 4'h0);

        // Asynchronous reset mid-handshake
        Rst_n = 1'b0;
        #1;
        check_out("midreset", 1'b0, 16'h0000, 4'h0, 4'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        scan_frame(F1234);
        scan_frame(F1234);
        scan_frame(F1234);
        check_out("post_reset", 1'b1, 16'h4321, 4'h0, 4'h0);
        do_ack();
        scan_frame(F1234);
        check_eq("t2_no_redeliver", bus.Valid_out, 1'b0);

        // Blank and illegal patterns
        scan_frame(FBLER);
        scan_frame(FBLER);
        check_eq("t3_not_yet", bus.Valid_out, 1'b0);
        scan_frame(FBLER);
        check_out("t3_blank_err", 1'b1, 16'h0F21, 4'b0100, 4'b1000);
        do_ack();

        // Alternating frames never become stable
        for (int i = 0; i < 5; i++) begin
            scan_frame((i % 2 == 0) ? F1234 : F1235);
            check_eq("t4_alt_quiet", bus.Valid_out, 1'b0);
        end
        scan_frame(F1235);
        scan_frame(F1235);
        check_eq("t4_two_of_three", bus.Valid_out, 1'b0);
        scan_frame(F1235);
        check_out("t4_deliver", 1'b1, 16'h5321, 4'h0, 4'h0);
        do_ack();

        // Partial frame with a bad digit3, then a multi-hot cycle discards it
        show(1, 7'h24, 3);
        show(2, 7'h30, 3);
        show(3, 7'h12, 3);
        bus.Dig_en_n = 4'b0011;
        @(negedge Clk);
        scan_frame(F1234);
        // Single-cycle digit3 pulse with a wrong pattern must not be captured
        show(0, 7'h79, 3);
        show(1, 7'h24, 3);
        show(3, 7'h12, 1);
        show(2, 7'h30, 3);
        show(3, 7'h19, 3);
        check_eq("t5_delayed", bus.Valid_out, 1'b0);
        scan_frame(F1234);
        check_out("t5_deliver", 1'b1, 16'h4321, 4'h0, 4'h0);
        do_ack();

        // Frozen outputs while the display changes, then ack colliding with a completion
        scan_frame(F1235);
        scan_frame(F1235);
        scan_frame(F1235);
        check_out("t6_deliver", 1'b1, 16'h5321, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            scan_frame(F1234);
            check_eq("t6_frozen_valid", bus.Valid_out, 1'b1);
            check_eq("t6_frozen_digits", bus.Digits_out, 16'h5321);
        end
        for (int k = 0; k < ND - 1; k++) show(k, F1234[7*k +: 7], 3);
        show(3, 7'h19, 2);
        bus.Ack_in = 1'b1;
        @(negedge Clk);
        bus.Ack_in = 1'b0;
        check_eq("t6_ack_wins", bus.Valid_out, 1'b0);
        @(negedge Clk);
        check_out("t6_rerise", 1'b1, 16'h4321, 4'h0, 4'h0);
        do_ack();
        scan_frame(F1234);
        check_eq("t6_never_again_1", bus.Valid_out, 1'b0);
        scan_frame(F1234);
        check_eq("t6_never_again_2", bus.Valid_out, 1'b0);
        check_eq("t6_outputs_kept", bus.Digits_out, 16'h4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
